// File: rtl/crossbar_pkg.sv
// Shared crossbar constants and the per-output lock state encoding.
package crossbar_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_WIDTH = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;
endpackage

// File: rtl/crossbar_rr_arb.sv
// Single-output rotating-priority arbiter with packet lock; purely combinational.
// A locked output only grants its owner; otherwise the first requester at or after i_ptr wins.
module crossbar_rr_arb
  import crossbar_pkg::*;
#(
  parameter int N = NUM_PORTS,
  parameter int W = PORT_WIDTH
) (
  input  logic [N-1:0] i_req,
  input  logic         i_elig,
  input  logic [W-1:0] i_ptr,
  input  logic         i_locked,
  input  logic [W-1:0] i_owner,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_win,
  output logic         o_any
);
  logic [W-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    if (i_elig) begin
      if (i_locked) begin
        if (i_req[i_owner]) begin
          o_any = 1'b1;
          o_win = i_owner;
        end
      end else begin
        // Scan farthest offset first so the nearest requester after i_ptr overrides.
        for (int k = N - 1; k >= 0; k--) begin
          w_idx = i_ptr + W'(k);
          if (i_req[w_idx]) begin
            o_any = 1'b1;
            o_win = w_idx;
          end
        end
      end
    end
    if (o_any) o_gnt[o_win] = 1'b1;
  end
endmodule

// File: rtl/crossbar_sched.sv
// Packet-aware round-robin scheduler for the 4x4 input-queued crossbar.
// rd_en is combinational in the grant cycle; out_vld/out_sel/lock_vec follow one cycle later.
module crossbar_sched
  import crossbar_pkg::*;
#(
  parameter int NUM_PORTS  = crossbar_pkg::NUM_PORTS,
  parameter int PORT_WIDTH = crossbar_pkg::PORT_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_enable,
  input  logic [NUM_PORTS-1:0]             i_req_valid,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  i_req_dst,
  input  logic [NUM_PORTS-1:0]             i_req_eop,
  input  logic [NUM_PORTS-1:0]             i_out_ready,
  output logic [NUM_PORTS-1:0]             o_rd_en,
  output logic [NUM_PORTS-1:0]             o_out_vld,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  o_out_sel,
  output logic [NUM_PORTS-1:0]             o_lock_vec
);
  lock_state_e           r_state   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] r_owner   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] r_ptr     [NUM_PORTS];
  logic [PORT_WIDTH-1:0] r_sel     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_out_vld;

  lock_state_e           w_state_nxt [NUM_PORTS];
  logic [PORT_WIDTH-1:0] w_owner_nxt [NUM_PORTS];
  logic [PORT_WIDTH-1:0] w_ptr_nxt   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_req_mask  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_gnt       [NUM_PORTS];
  logic [PORT_WIDTH-1:0] w_win       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_any;

  // Each input asks for exactly one output, so per-output masks never overlap.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_req_mask[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req_mask[j][i] = i_req_valid[i] &&
                           (i_req_dst[i*PORT_WIDTH +: PORT_WIDTH] == PORT_WIDTH'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    crossbar_rr_arb #(
      .N (NUM_PORTS),
      .W (PORT_WIDTH)
    ) u_arb (
      .i_req    (w_req_mask[j]),
      .i_elig   (i_enable && i_out_ready[j] && !i_rst),
      .i_ptr    (r_ptr[j]),
      .i_locked (r_state[j] == ST_LOCKED),
      .i_owner  (r_owner[j]),
      .o_gnt    (w_gnt[j]),
      .o_win    (w_win[j]),
      .o_any    (w_any[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_state_nxt[j] = r_state[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
      if (w_any[j]) begin
        if (i_req_eop[w_win[j]]) begin
          w_state_nxt[j] = ST_IDLE;
          w_ptr_nxt[j]   = w_win[j] + 1'b1;
        end else if (r_state[j] == ST_IDLE) begin
          w_state_nxt[j] = ST_LOCKED;
          w_owner_nxt[j] = w_win[j];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        r_state[j] <= ST_IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
        r_sel[j]   <= '0;
      end
      r_out_vld <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
        if (w_any[j]) r_sel[j] <= w_win[j];
      end
      r_out_vld <= w_any;
    end
  end

  always_comb begin
    o_rd_en    = '0;
    o_out_sel  = '0;
    o_lock_vec = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      o_rd_en                             = o_rd_en | w_gnt[j];
      o_out_sel[j*PORT_WIDTH +: PORT_WIDTH] = r_sel[j];
      o_lock_vec[j]                       = (r_state[j] == ST_LOCKED);
    end
  end

  assign o_out_vld = r_out_vld;
endmodule

// File: tb/tb_crossbar_sched.sv
// Bench for crossbar_sched: directed table, hand-written lock/backpressure/reset sequences,
// then random traffic against a behavioural per-output scheduler model.
module tb_crossbar_sched;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] vld, eop, rdy;
  logic [7:0] dst;
  logic [3:0] rd_en, out_vld, lock_vec;
  logic [7:0] out_sel;

  int n_err = 0;
  int n_chk = 0;

  int         m_ptr   [4];
  int         m_owner [4];
  bit         m_lock  [4];
  logic [3:0] m_vld;
  logic [7:0] m_sel;

  typedef struct {
    logic [3:0] vld;
    logic [7:0] dst;
    logic [3:0] eop;
    logic [3:0] rdy;
    logic [3:0] e_rd;
    logic [3:0] e_vld;
    logic [7:0] e_sel;
    logic [3:0] e_lock;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  crossbar_sched dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_req_valid (vld),
    .i_req_dst   (dst),
    .i_req_eop   (eop),
    .i_out_ready (rdy),
    .o_rd_en     (rd_en),
    .o_out_vld   (out_vld),
    .o_out_sel   (out_sel),
    .o_lock_vec  (lock_vec)
  );

  function automatic int dst_of(logic [7:0] d, int i);
    return int'((d >> (2 * i)) & 8'h3);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check rd_en combinationally, advance model, check registers.
  task automatic step(input string tag, input logic r, input logic e, input logic [3:0] v,
                      input logic [7:0] d, input logic [3:0] eo, input logic [3:0] rd,
                      output logic [3:0] rd_obs);
    int win [4];
    logic [3:0] exp_rd;
    logic [3:0] lv;
    @(negedge clk);
    rst = r; en = e; vld = v; dst = d; eop = eo; rdy = rd;
    #1;
    exp_rd = '0;
    for (int j = 0; j < 4; j++) begin
      win[j] = -1;
      if (!r && e && rd[j]) begin
        if (m_lock[j]) begin
          if (v[m_owner[j]] && dst_of(d, m_owner[j]) == j) win[j] = m_owner[j];
        end else begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr[j] + k) % 4;
            if (win[j] < 0 && v[i] && dst_of(d, i) == j) win[j] = i;
          end
        end
      end
      if (win[j] >= 0) exp_rd[win[j]] = 1'b1;
    end
    rd_obs = rd_en;
    chk({tag, " rd_en"}, {4'h0, rd_en}, {4'h0, exp_rd});

    if (r) begin
      for (int j = 0; j < 4; j++) begin
        m_ptr[j] = 0; m_owner[j] = 0; m_lock[j] = 0;
      end
      m_vld = '0;
      m_sel = '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        m_vld[j] = (win[j] >= 0);
        if (win[j] >= 0) begin
          m_sel[2*j +: 2] = 2'(win[j]);
          if (eo[win[j]]) begin
            m_lock[j] = 0;
            m_ptr[j]  = (win[j] + 1) % 4;
          end else if (!m_lock[j]) begin
            m_lock[j]  = 1;
            m_owner[j] = win[j];
          end
        end
      end
    end

    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) lv[j] = m_lock[j];
    chk({tag, " out_vld"}, {4'h0, out_vld}, {4'h0, m_vld});
    chk({tag, " out_sel"}, out_sel, m_sel);
    chk({tag, " lock_vec"}, {4'h0, lock_vec}, {4'h0, lv});
  endtask

  initial begin
    logic [3:0] ro;
    rst = 1'b1; en = 1'b0; vld = '0; dst = '0; eop = '0; rdy = '0;

    // Round-robin on output 2, then a full permutation.
    tbl[0] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0001, 4'b0100, 8'h00, 4'h0};
    tbl[1] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0010, 4'b0100, 8'h10, 4'h0};
    tbl[2] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0100, 4'b0100, 8'h20, 4'h0};
    tbl[3] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b1000, 4'b0100, 8'h30, 4'h0};
    tbl[4] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0001, 4'b0100, 8'h00, 4'h0};
    tbl[5] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0010, 4'b0100, 8'h10, 4'h0};
    tbl[6] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b0100, 4'b0100, 8'h20, 4'h0};
    tbl[7] = '{4'hF, 8'hAA, 4'hF, 4'hF, 4'b1000, 4'b0100, 8'h30, 4'h0};
    tbl[8] = '{4'hF, 8'h1B, 4'hF, 4'hF, 4'b1111, 4'b1111, 8'h1B, 4'h0};
    tbl[9] = '{4'hF, 8'h1B, 4'hF, 4'hF, 4'b1111, 4'b1111, 8'h1B, 4'h0};

    step("reset0", 1'b1, 1'b1, 4'hF, 8'h00, 4'hF, 4'hF, ro);
    step("reset1", 1'b1, 1'b1, 4'hF, 8'h00, 4'hF, 4'hF, ro);
    chk("reset rd_en", {4'h0, ro}, 8'h00);
    chk("reset out_vld", {4'h0, out_vld}, 8'h00);
    chk("reset out_sel", out_sel, 8'h00);
    chk("reset lock_vec", {4'h0, lock_vec}, 8'h00);

    for (int n = 0; n < 10; n++) begin
      step("table", 1'b0, 1'b1, tbl[n].vld, tbl[n].dst, tbl[n].eop, tbl[n].rdy, ro);
      chk($sformatf("tbl%0d rd_en", n), {4'h0, ro}, {4'h0, tbl[n].e_rd});
      chk($sformatf("tbl%0d out_vld", n), {4'h0, out_vld}, {4'h0, tbl[n].e_vld});
      chk($sformatf("tbl%0d out_sel", n), out_sel, tbl[n].e_sel);
      chk($sformatf("tbl%0d lock_vec", n), {4'h0, lock_vec}, {4'h0, tbl[n].e_lock});
    end

    // Input 1 sends a 3-beat packet to output 0 while input 2 waits.
    step("lockA0", 1'b0, 1'b1, 4'b0110, 8'h00, 4'b0100, 4'hF, ro);
    chk("lockA0 rd", {4'h0, ro}, 8'h02);
    chk("lockA0 lock", {4'h0, lock_vec}, 8'h01);
    step("lockA1", 1'b0, 1'b1, 4'b0110, 8'h00, 4'b0100, 4'hF, ro);
    chk("lockA1 rd", {4'h0, ro}, 8'h02);
    step("lockA2", 1'b0, 1'b1, 4'b0110, 8'h00, 4'b0110, 4'hF, ro);
    chk("lockA2 rd", {4'h0, ro}, 8'h02);
    chk("lockA2 lock", {4'h0, lock_vec}, 8'h00);
    step("lockA3", 1'b0, 1'b1, 4'b0100, 8'h00, 4'b0110, 4'hF, ro);
    chk("lockA3 rd", {4'h0, ro}, 8'h04);

    // Owner goes empty mid-packet: output holds locked without granting.
    step("emptyB0", 1'b0, 1'b1, 4'b0110, 8'h00, 4'b0100, 4'hF, ro);
    chk("emptyB0 rd", {4'h0, ro}, 8'h02);
    for (int c = 0; c < 2; c++) begin
      step("emptyB", 1'b0, 1'b1, 4'b0100, 8'h00, 4'b0100, 4'hF, ro);
      chk("emptyB hold rd", {4'h0, ro}, 8'h00);
      chk("emptyB hold lock", {4'h0, lock_vec}, 8'h01);
      chk("emptyB hold vld", {4'h0, out_vld}, 8'h00);
    end
    step("emptyB3", 1'b0, 1'b1, 4'b0110, 8'h00, 4'b0110, 4'hF, ro);
    chk("emptyB3 rd", {4'h0, ro}, 8'h02);
    chk("emptyB3 lock", {4'h0, lock_vec}, 8'h00);
    step("emptyB4", 1'b0, 1'b1, 4'b0100, 8'h00, 4'b0100, 4'hF, ro);

    // Output 1 not ready: its requesters stall, output 2 keeps flowing.
    for (int c = 0; c < 3; c++) begin
      step("readyC", 1'b0, 1'b1, 4'hF, 8'h95, 4'hF, 4'b1101, ro);
      chk("readyC rd", {4'h0, ro}, 8'h08);
      chk("readyC vld", {4'h0, out_vld}, 8'h04);
    end
    step("readyC3", 1'b0, 1'b1, 4'hF, 8'h95, 4'hF, 4'hF, ro);
    chk("readyC3 rd", {4'h0, ro}, 8'h09);

    // Reset in the middle of a packet on output 3.
    step("rstD0", 1'b0, 1'b1, 4'b0001, 8'h03, 4'b0000, 4'hF, ro);
    chk("rstD0 lock", {4'h0, lock_vec}, 8'h08);
    step("rstD1", 1'b1, 1'b1, 4'b0001, 8'h03, 4'b0000, 4'hF, ro);
    chk("rstD1 rd", {4'h0, ro}, 8'h00);
    chk("rstD1 lock", {4'h0, lock_vec}, 8'h00);
    chk("rstD1 vld", {4'h0, out_vld}, 8'h00);
    step("rstD2", 1'b0, 1'b1, 4'b1001, 8'hC3, 4'hF, 4'hF, ro);
    chk("rstD2 rd", {4'h0, ro}, 8'h01);

    for (int c = 0; c < 400; c++) begin
      logic       r, e;
      logic [3:0] v, eo, rd;
      logic [7:0] d;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 9) != 0);
      v  = 4'($urandom);
      d  = 8'($urandom);
      eo = 4'($urandom);
      rd = 4'($urandom) | 4'($urandom);
      step("rand", r, e, v, d, eo, rd, ro);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
